mdio_master: RTL

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_pkg.sv | 30 +++
 rtl/mdio_master_mdc_gen.sv | 44 ++++
 rtl/mdio_master.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared frame constants, FSM state type and frame-layout helpers for the MDIO master.
package mdio_pkg;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_TA, S_DATA, S_END} state_e;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    localparam int PRE_LEN  = 32;
    localparam int CMD_LEN  = 14;
    localparam int TA_LEN   = 2;
    localparam int DATA_LEN = 16;

    // Number of MDC periods spent in each state; END is a single released bit.
    function automatic logic [5:0] state_len(input state_e s);
        return s == S_PRE  ? 6'(PRE_LEN)  :
               s == S_CMD  ? 6'(CMD_LEN)  :
               s == S_TA   ? 6'(TA_LEN)   :
               s == S_DATA ? 6'(DATA_LEN) : 6'd1;
    endfunction

    function automatic state_e next_state(input state_e s);
        return s == S_PRE  ? S_CMD  :
               s == S_CMD  ? S_TA   :
               s == S_TA   ? S_DATA :
               s == S_DATA ? S_END  : S_IDLE;
    endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// mdc_gen: MDC divider producing the management clock and bit-timing strobes.
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : frame active; counter is held at 0 while low
//   mdc        : registered MDC, low for the first half of each period
//   bit_end    : last clk of an MDC period; bit state updated here lands on the MDC fall
//   sample     : clk in which MDC rises; mdio_i is captured here
module mdc_gen #(
    parameter int CLK_DIV = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic bit_end,
    output logic sample
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;

    always_comb begin
        cnt_d = (!en || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        mdc_d = cnt_d >= HALF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc     = mdc_q;
    assign bit_end = en && cnt_q == LAST;
    assign sample  = en && cnt_q == HALF;

endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master issuing single read/write frames.
//   clk, rst_n          : system clock, synchronous active-low reset
//   req/wr/reg_addr/wdata : request and its operands, captured while not busy
//   busy, done          : frame in progress (through done), one-cycle completion pulse
//   rdata, rd_err       : read result and missing-turnaround flag, updated at done
//   mdc, mdio_o, mdio_oe, mdio_i : PHY management pins (tristate buffer is external)
module mdio_master import mdio_pkg::*; #(
    parameter int         CLK_DIV  = 40,
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        rd_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    state_e      state_q, state_d;
    logic [5:0]  bit_q, bit_d;
    logic        wr_q, wr_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        rd_err_q, rd_err_d;
    logic        done_q, done_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic [13:0] cmd;
    logic        active, accept, bit_end, sample, last_bit, fin;

    assign active   = state_q != S_IDLE;
    // The done cycle is already IDLE but still counts as busy, forcing one idle clk between frames.
    assign accept   = !active && !done_q && req;
    assign last_bit = bit_q == state_len(state_q) - 6'd1;
    assign fin      = state_q == S_END && bit_end && last_bit;

    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (active),
        .mdc     (mdc),
        .bit_end (bit_end),
        .sample  (sample)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sh_q      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rd_err_q  <= 1'b0;
            done_q    <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sh_q      <= sh_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rd_err_q  <= rd_err_d;
            done_q    <= done_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
        end
    end

    // Bit position moves on the last clk of each MDC period so every new bit appears with the MDC fall.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        if (accept) begin
            state_d = S_PRE;
            bit_d   = '0;
        end else if (bit_end) begin
            state_d = last_bit ? next_state(state_q) : state_q;
            bit_d   = last_bit ? '0 : bit_q + 6'd1;
        end
    end

    always_comb begin
        wr_d     = accept ? wr : wr_q;
        addr_d   = accept ? reg_addr : addr_q;
        wdata_d  = accept ? wdata : wdata_q;
        sh_d     = (sample && state_q == S_DATA) ? {sh_q[14:0], mdio_i} : sh_q;
        // A present PHY pulls the second turnaround bit low; a high sample there means nobody answered.
        err_d    = accept ? 1'b0 : err_q | (sample && !wr_q && state_q == S_TA && bit_q == 6'd1 && mdio_i);
        done_d   = fin;
        rdata_d  = (fin && !wr_q) ? sh_q : rdata_q;
        rd_err_d = fin ? (err_q && !wr_q) : rd_err_q;
    end

    // Pin values are derived from the next bit position and registered, so they only move with it.
    always_comb begin
        cmd       = {ST, wr_d ? OP_WR : OP_RD, PHY_ADDR, addr_d};
        mdio_oe_d = state_d == S_PRE || state_d == S_CMD || (wr_d && (state_d == S_TA || state_d == S_DATA));
        mdio_o_d  = !mdio_oe_d         ? 1'b1 :
                    state_d == S_CMD  ? cmd[4'(6'd13 - bit_d)] :
                    state_d == S_TA   ? bit_d == 6'd0 :
                    state_d == S_DATA ? wdata_d[4'(6'd15 - bit_d)] : 1'b1;
    end

    assign busy    = active || done_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign rd_err  = rd_err_q;
    assign mdio_o  = mdio_o_q;
    assign mdio_oe = mdio_oe_q;

endmodule
